// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: refresh > write > read, one grant at a time.
// Drives the SDRAM pins from whichever block currently owns the bus.
module sdram_arbiter #(
  parameter logic [3:0] CMD_NOP = 4'b0111,
  parameter int         DATA_W  = 16
) (
  input  logic              clk_100,
  input  logic              rst_n_lock,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_ba,
  input  logic [12:0]       init_addr,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic [3:0]        aref_cmd,
  input  logic [1:0]        aref_ba,
  input  logic [12:0]       aref_addr,
  input  logic              aref_end,
  input  logic              wr_req,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_ba,
  input  logic [12:0]       wr_addr,
  input  logic              wr_end,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_ba,
  input  logic [12:0]       rd_addr,
  input  logic              rd_end,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_ba,
  output logic [12:0]       sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  typedef enum logic [2:0] {
    INIT, ARBIT, AREF, WRITE, READ
  } state_t;

  state_t state_q, state_d;
  logic   aref_en_q, aref_en_d;
  logic   wr_en_q, wr_en_d;
  logic   rd_en_q, rd_en_d;

  always_ff @(posedge clk_100 or negedge rst_n_lock) begin
    if (!rst_n_lock) begin
      state_q   <= INIT;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      aref_en_q <= aref_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
    end
  end

  // Every operation returns through ARBIT, guaranteeing a NOP gap.
  always_comb begin
    state_d   = state_q;
    aref_en_d = aref_en_q;
    wr_en_d   = wr_en_q;
    rd_en_d   = rd_en_q;
    unique case (state_q)
      INIT: begin
        if (init_end) state_d = ARBIT;
      end
      ARBIT: begin
        if (aref_req) begin
          state_d   = AREF;
          aref_en_d = 1'b1;
        end else if (wr_req) begin
          state_d = WRITE;
          wr_en_d = 1'b1;
        end else if (rd_req) begin
          state_d = READ;
          rd_en_d = 1'b1;
        end
      end
      AREF: begin
        if (aref_end) begin
          state_d   = ARBIT;
          aref_en_d = 1'b0;
        end
      end
      WRITE: begin
        if (wr_end) begin
          state_d = ARBIT;
          wr_en_d = 1'b0;
        end
      end
      READ: begin
        if (rd_end) begin
          state_d = ARBIT;
          rd_en_d = 1'b0;
        end
      end
      default: begin
        state_d   = INIT;
        aref_en_d = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
      end
    endcase
  end

  logic [3:0] cmd;

  always_comb begin
    cmd        = CMD_NOP;
    sdram_ba   = 2'b11;
    sdram_addr = 13'h1fff;
    unique case (state_q)
      INIT: begin
        cmd        = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      AREF: begin
        cmd        = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        cmd        = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      READ: begin
        cmd        = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

  assign sdram_cke    = 1'b1;
  assign sdram_dq_oe  = wr_sdram_en && (state_q == WRITE);
  assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : '0;

  assign aref_en = aref_en_q;
  assign wr_en   = wr_en_q;
  assign rd_en   = rd_en_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter.
// Expected pin bundles are queued per cycle and checked on the falling edge.
module tb_sdram_arbiter;

  localparam int DW = 16;

  localparam int S_INIT = 0;
  localparam int S_NOP  = 1;
  localparam int S_AREF = 2;
  localparam int S_WR   = 3;
  localparam int S_RD   = 4;

  logic          clk_100 = 1'b0;
  logic          rst_n_lock;
  logic [3:0]    init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]    init_ba, aref_ba, wr_ba, rd_ba;
  logic [12:0]   init_addr, aref_addr, wr_addr, rd_addr;
  logic          init_end, aref_req, aref_end;
  logic          wr_req, wr_end, wr_sdram_en;
  logic [DW-1:0] wr_sdram_data;
  logic          rd_req, rd_end;
  logic          aref_en, wr_en, rd_en;
  logic          sdram_cke, sdram_cs_n, sdram_ras_n;
  logic          sdram_cas_n, sdram_we_n;
  logic [1:0]    sdram_ba;
  logic [12:0]   sdram_addr;
  logic [DW-1:0] sdram_dq_out;
  logic          sdram_dq_oe;

  sdram_arbiter #(.CMD_NOP(4'b0111), .DATA_W(DW)) dut (
    .clk_100(clk_100), .rst_n_lock(rst_n_lock),
    .init_cmd(init_cmd), .init_ba(init_ba),
    .init_addr(init_addr), .init_end(init_end),
    .aref_req(aref_req), .aref_cmd(aref_cmd),
    .aref_ba(aref_ba), .aref_addr(aref_addr),
    .aref_end(aref_end),
    .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_ba(wr_ba),
    .wr_addr(wr_addr), .wr_end(wr_end),
    .wr_sdram_en(wr_sdram_en),
    .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_ba(rd_ba),
    .rd_addr(rd_addr), .rd_end(rd_end),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n),
    .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
    .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out),
    .sdram_dq_oe(sdram_dq_oe)
  );

  always #5 clk_100 = ~clk_100;

  // {en[2:0], cmd, ba, addr, cke, oe, dq}
  typedef logic [3+4+2+13+1+1+DW-1:0] bundle_t;

  bundle_t exp_q[$];
  string   tag_q[$];
  int      n_cmp = 0;
  int      n_bad = 0;

  function automatic bundle_t actual();
    return {aref_en, wr_en, rd_en,
            sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
            sdram_ba, sdram_addr, sdram_cke,
            sdram_dq_oe, sdram_dq_out};
  endfunction

  always @(negedge clk_100) begin
    if (exp_q.size() != 0) begin
      bundle_t e, a;
      string   t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = actual();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", t, a, e);
      end
    end
  end

  // Queue the expected bundle for the current cycle, then advance.
  task automatic cyc(input int sel, input logic oe, input string t);
    logic [2:0]  en;
    logic [3:0]  c;
    logic [1:0]  b;
    logic [12:0] ad;
    en = 3'b000;
    c  = 4'b0111;
    b  = 2'b11;
    ad = 13'h1fff;
    case (sel)
      S_INIT: begin
        c = init_cmd; b = init_ba; ad = init_addr;
      end
      S_AREF: begin
        en = 3'b100;
        c = aref_cmd; b = aref_ba; ad = aref_addr;
      end
      S_WR: begin
        en = 3'b010;
        c = wr_cmd; b = wr_ba; ad = wr_addr;
      end
      S_RD: begin
        en = 3'b001;
        c = rd_cmd; b = rd_ba; ad = rd_addr;
      end
      default: ;
    endcase
    exp_q.push_back({en, c, b, ad, 1'b1, oe,
                     oe ? wr_sdram_data : {DW{1'b0}}});
    tag_q.push_back(t);
    @(posedge clk_100);
    #1;
  endtask

  initial begin
    rst_n_lock    = 1'b0;
    init_cmd      = 4'b0010;
    init_ba       = 2'b00;
    init_addr     = 13'h0400;
    init_end      = 1'b0;
    aref_cmd      = 4'b0001;
    aref_ba       = 2'b01;
    aref_addr     = 13'h0aaa;
    aref_req      = 1'b0;
    aref_end      = 1'b0;
    wr_cmd        = 4'b0100;
    wr_ba         = 2'b10;
    wr_addr       = 13'h0123;
    wr_req        = 1'b0;
    wr_end        = 1'b0;
    wr_sdram_en   = 1'b0;
    wr_sdram_data = 16'h0000;
    rd_cmd        = 4'b0101;
    rd_ba         = 2'b10;
    rd_addr       = 13'h0456;
    rd_req        = 1'b0;
    rd_end        = 1'b0;

    @(posedge clk_100);
    #1;
    cyc(S_INIT, 1'b0, "reset");
    rst_n_lock = 1'b1;
    for (int i = 1; i < 10; i++) cyc(S_INIT, 1'b0, "init_hold");
    init_end = 1'b1;
    cyc(S_INIT, 1'b0, "init_end_cycle");
    init_end = 1'b0;
    cyc(S_NOP, 1'b0, "arbit_nop");

    aref_req = 1'b1;
    cyc(S_NOP, 1'b0, "aref_req_sampled");
    aref_req = 1'b0;
    cyc(S_AREF, 1'b0, "aref_grant");
    cyc(S_AREF, 1'b0, "aref_hold");
    aref_end = 1'b1;
    cyc(S_AREF, 1'b0, "aref_end_cycle");
    aref_end = 1'b0;
    cyc(S_NOP, 1'b0, "aref_done_nop");

    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    cyc(S_NOP, 1'b0, "all_req");
    aref_req = 1'b0; aref_end = 1'b1;
    cyc(S_AREF, 1'b0, "prio_aref");
    aref_end = 1'b0;
    cyc(S_NOP, 1'b0, "gap_after_aref");
    wr_req = 1'b0;
    cyc(S_WR, 1'b0, "prio_wr");
    wr_sdram_en = 1'b1; wr_sdram_data = 16'hA5A5;
    cyc(S_WR, 1'b1, "wr_dq_drive");
    wr_sdram_en = 1'b0; rd_end = 1'b1;
    cyc(S_WR, 1'b0, "wr_oe_off_rd_end");
    rd_end = 1'b0; aref_end = 1'b1;
    cyc(S_WR, 1'b0, "wr_ignore_aref_end");
    aref_end = 1'b0; wr_end = 1'b1;
    cyc(S_WR, 1'b0, "wr_end_cycle");
    wr_end = 1'b0;
    cyc(S_NOP, 1'b0, "gap_after_wr");
    rd_req = 1'b0;
    cyc(S_RD, 1'b0, "prio_rd");
    aref_req = 1'b1;
    cyc(S_RD, 1'b0, "rd_no_preempt");
    cyc(S_RD, 1'b0, "rd_no_preempt2");
    rd_end = 1'b1;
    cyc(S_RD, 1'b0, "rd_end_cycle");
    rd_end = 1'b0;
    cyc(S_NOP, 1'b0, "gap_after_rd");
    aref_req = 1'b0; aref_end = 1'b1;
    cyc(S_AREF, 1'b0, "aref_after_rd");
    aref_end = 1'b0;
    cyc(S_NOP, 1'b0, "idle_nop");

    wr_req = 1'b1;
    cyc(S_NOP, 1'b0, "wr_req2");
    wr_req = 1'b0; wr_sdram_en = 1'b1;
    wr_sdram_data = 16'h5A5A;
    cyc(S_WR, 1'b1, "wr2_drive");
    rst_n_lock = 1'b0;
    cyc(S_INIT, 1'b0, "mid_wr_reset");
    rst_n_lock = 1'b1; wr_sdram_en = 1'b0;
    wr_req = 1'b1; wr_end = 1'b1;
    cyc(S_INIT, 1'b0, "reinit_ignore_req");
    wr_end = 1'b0;
    cyc(S_INIT, 1'b0, "reinit_hold");
    init_end = 1'b1;
    cyc(S_INIT, 1'b0, "reinit_end");
    init_end = 1'b0;
    cyc(S_NOP, 1'b0, "reinit_nop");
    wr_req = 1'b0; wr_end = 1'b1;
    cyc(S_WR, 1'b0, "wr3_grant_end");
    wr_end = 1'b0;
    cyc(S_NOP, 1'b0, "final_nop");

    @(negedge clk_100);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0",
               exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
